// File: rtl/data_mem_responder_pkg.sv
// Shared types and source-index encoding for the data memory responder.
// Source 2c is the write of channel c, source 2c+1 is the read of channel c.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESPOND
  } state_t;

  localparam int STATS_BITS = 16;

  function automatic int src_index(input int channel, input bit is_read);
    return 2 * channel + (is_read ? 1 : 0);
  endfunction

  function automatic int src_channel(input int src);
    return src / 2;
  endfunction

  function automatic bit src_is_read(input int src);
    return (src % 2) == 1;
  endfunction

endpackage

// File: rtl/data_mem_responder_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requesting source
// at or after the pointer, returning both a one-hot grant and its index.
module rr_arbiter #(
  parameter int NUM_SRC  = 8,
  parameter int IDX_BITS = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0]  req,
  input  logic [IDX_BITS-1:0] ptr,
  output logic [NUM_SRC-1:0]  grant,
  output logic [IDX_BITS-1:0] grant_idx
);

  logic [IDX_BITS-1:0] cand;
  logic                found;

  // NOTE: every variable written here gets a default first, so no path
  // through the loop can leave it unassigned and infer a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand = IDX_BITS'((int'(ptr) + i) % NUM_SRC);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-port data memory shared by NUM_CHANNELS LSU channels, serviced one
// request at a time. Define DATA_MEM_RESPONDER_STATS_EN for access counters.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int LATENCY      = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] read_valid,
  input  logic [ADDR_BITS-1:0]    read_address [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0] read_ready,
  output logic [DATA_BITS-1:0]    read_data    [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0] write_valid,
  input  logic [ADDR_BITS-1:0]    write_address[NUM_CHANNELS],
  input  logic [DATA_BITS-1:0]    write_data   [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0] write_ready
`ifdef DATA_MEM_RESPONDER_STATS_EN
  ,
  output logic [STATS_BITS-1:0]   read_count,
  output logic [STATS_BITS-1:0]   write_count
`endif
);

  localparam int NUM_SRC  = 2 * NUM_CHANNELS;
  localparam int SRC_BITS = $clog2(NUM_SRC);
  localparam int DEPTH    = 1 << ADDR_BITS;

  logic [DATA_BITS-1:0] mem [DEPTH];

  state_t               state;
  logic [SRC_BITS-1:0]  ptr;
  logic [3:0]           cnt;
  logic [SRC_BITS-1:0]  lat_src;
  logic [ADDR_BITS-1:0] lat_addr;
  logic [DATA_BITS-1:0] lat_wdata;

  logic [NUM_SRC-1:0]   req;
  logic [NUM_SRC-1:0]   grant;
  logic [SRC_BITS-1:0]  arb_idx;
  logic [ADDR_BITS-1:0] sel_addr;
  logic [DATA_BITS-1:0] sel_wdata;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_req
    assign req[src_index(c, 1'b0)] = write_valid[c];
    assign req[src_index(c, 1'b1)] = read_valid[c];
  end

  rr_arbiter #(
    .NUM_SRC  (NUM_SRC),
    .IDX_BITS (SRC_BITS)
  ) u_arb (
    .req       (req),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (arb_idx)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (src_channel(int'(arb_idx)) == c) begin
        sel_addr  = src_is_read(int'(arb_idx)) ? read_address[c] : write_address[c];
        sel_wdata = write_data[c];
      end
    end
  end

  // NOTE: the storage array is cleared by reset, so it is built from
  // flops rather than a RAM macro; only the granted word changes per access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      cnt         <= '0;
      lat_src     <= '0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      read_ready  <= '0;
      write_ready <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) read_data[c] <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
`ifdef DATA_MEM_RESPONDER_STATS_EN
      read_count  <= '0;
      write_count <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (|grant) begin
            lat_src   <= arb_idx;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
            ptr       <= SRC_BITS'((int'(arb_idx) + 1) % NUM_SRC);
            cnt       <= 4'(LATENCY - 1);
            state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt == 4'd0) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
              if (src_channel(int'(lat_src)) == c) begin
                if (lat_src[0]) begin
                  read_data[c]  <= mem[lat_addr];
                  read_ready[c] <= 1'b1;
                end else begin
                  write_ready[c] <= 1'b1;
                end
              end
            end
            if (!lat_src[0]) mem[lat_addr] <= lat_wdata;
`ifdef DATA_MEM_RESPONDER_STATS_EN
            if (lat_src[0] && read_count != '1) read_count <= read_count + 1'b1;
            if (!lat_src[0] && write_count != '1) write_count <= write_count + 1'b1;
`endif
            state <= ST_RESPOND;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESPOND: begin
          // Ready is held until the granted source itself withdraws its valid.
          if (!req[lat_src]) begin
            read_ready  <= '0;
            write_ready <= '0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, meaning address width; storage depth is 2**ADDR_BITS words.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning word width.
REQ-003 SHALL have parameter NUM_CHANNELS, default 4, meaning number of requester channels (one per thread LSU).
REQ-004 SHALL have parameter LATENCY, default 2, meaning cycles from grant to access; legal range 1..15.
REQ-005 SHALL have ports: clk  in  1  sole clock, rising edge; reset  in  1  synchronous, active-high.
REQ-006 SHALL have ports: read_valid  in  [NUM_CHANNELS]  read request held per channel; read_address  in  ADDR_BITS x NUM_CHANNELS (unpacked)  read address.
REQ-007 SHALL have ports: read_ready  out  [NUM_CHANNELS]  read response; read_data  out  DATA_BITS x NUM_CHANNELS (unpacked)  read word.
REQ-008 SHALL have ports: write_valid  in  [NUM_CHANNELS]; write_address  in  ADDR_BITS x NUM_CHANNELS; write_data  in  DATA_BITS x NUM_CHANNELS; write_ready  out  [NUM_CHANNELS]  write acknowledge.

Function
REQ-009 SHALL use a single-port internal storage array servicing exactly one request at a time.
REQ-010 SHALL number 2*NUM_CHANNELS sources: source 2c = write of channel c, source 2c+1 = read of channel c.
REQ-011 SHALL run FSM IDLE -> BUSY -> RESPOND -> IDLE, encoded in a shared-package enum.
REQ-012 SHALL, in IDLE at an edge where any source valid is high, grant the first valid source at or after the round-robin pointer, latch its address/data, load counter LATENCY-1, and enter BUSY.
REQ-013 SHALL, in BUSY, decrement the counter each edge; at the edge where counter is 0, perform the access and enter RESPOND with the granted ready high.
REQ-014 SHALL make ready visible starting after edge k+LATENCY for valid sampled at edge k; a write commits at that same edge; read_data is registered at that edge and held stable while ready is high.
REQ-015 SHALL hold the granted ready high in RESPOND until an edge samples that source's valid low; at that edge ready drops and FSM returns IDLE; next grant no earlier than the following edge.
REQ-016 SHALL set the round-robin pointer to (granted source + 1) mod 2*NUM_CHANNELS on each grant.
REQ-017 SHALL, when read and write of one channel are both valid, resolve by the source order of REQ-010 (write first).
REQ-018 SHALL ignore valid changes and address/data changes of the granted source between grant and RESPOND; latched values are used.
REQ-019 SHALL wrap addresses naturally in ADDR_BITS; no out-of-range condition exists.
REQ-020 SHALL keep every ready of non-granted sources low at all times; at most one ready bit across both vectors high.

Reset
REQ-021 SHALL on reset: FSM IDLE, pointer 0, counter 0, all read_ready/write_ready 0, all read_data 0, storage cleared to 0.
REQ-022 SHALL on reset mid-transaction drop the pending request without committing it; reset dominates all other events.

Configuration
REQ-023 SHALL, with macro DATA_MEM_RESPONDER_STATS_EN defined, add outputs read_count and write_count (16 bits each), incremented at each read/write access edge, saturating at 0xFFFF, reset to 0.
REQ-024 SHALL, without DATA_MEM_RESPONDER_STATS_EN, omit those ports and counters entirely; all other behaviour identical.

Structure
REQ-025 SHALL place the FSM state enum and the source-index encoding helper in shared package data_mem_responder_pkg.
REQ-026 SHALL implement arbitration in one sub-module rr_arbiter (request vector, pointer in; one-hot grant, grant index out), combinational, instantiated once.

Verification
REQ-027 Reset then channel 0 write addr 0x10 data 0xA5 at edge k -> write_ready[0] high after edge k+2; storage[0x10]=0xA5.
REQ-028 Then channel 2 read addr 0x10 -> read_ready[2] high after 2 edges, read_data[2]=0xA5, held until read_valid[2] dropped; ready low the edge after.
REQ-029 All four channels read valid simultaneously, pointer 0 -> service order channels 0,1,2,3; exactly one ready high at any time.
REQ-030 Channel 1 read and write both valid, addr 0x20, data 0x3C -> write served first, then read returns 0x3C.
REQ-031 Reset asserted in BUSY of write addr 0x05 data 0xFF -> no ready, storage[0x05]=0, FSM IDLE.
REQ-032 With DATA_MEM_RESPONDER_STATS_EN: 3 writes, 2 reads -> write_count=3, read_count=2; LATENCY=1 build: ready after edge k+1.
